io_port_bridge: RTL and testbench



---
 rtl/io_bridge_pkg.sv | 16 +
 rtl/io_fifo.sv | 65 ++++++
 rtl/io_port_bridge.sv | 96 +++++++++
 tb/tb_io_port_bridge.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/io_bridge_pkg.sv
// Shared types and constants for the CPU IO port bridge.
package io_bridge_pkg;

  typedef struct packed {
    logic [7:0] id;
    logic [7:0] data;
  } io_entry_t;

  localparam logic [7:0]  STATUS_ID_DEFAULT = 8'hFF;

  localparam int unsigned STAT_FULL    = 0;
  localparam int unsigned STAT_VALID   = 1;
  localparam int unsigned STAT_OVF     = 2;
  localparam int unsigned CTRL_CLR_OVF = 0;

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO of io_entry_t; a push while full is accepted only alongside a pop.
module io_fifo
  import io_bridge_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  io_entry_t                  wdata_i,
  input  logic                       pop_i,
  output io_entry_t                  rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  io_entry_t         mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/io_port_bridge.sv
// Queues CPU OUTPUT writes toward a peripheral and muxes in_port read data.
// Optional drain-complete interrupt enabled with `define IO_BRIDGE_IRQ_EN.
module io_port_bridge
  import io_bridge_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter logic [7:0]  STATUS_ID = STATUS_ID_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       io_strb,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  output logic [7:0] in_port,
  input  logic [7:0] periph_rd_data,
  output logic       periph_valid,
  output logic [7:0] periph_id,
  output logic [7:0] periph_data,
  input  logic       periph_ready,
  output logic       fifo_full,
  output logic       irq
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          is_status;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  io_entry_t     wentry;
  io_entry_t     head;
  logic          overflow_q, overflow_d;

  assign is_status = (port_id == STATUS_ID);
  assign push      = io_strb && !is_status;
  assign pop       = periph_valid && periph_ready;
  assign wentry    = '{id: port_id, data: out_port};

  io_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (wentry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign periph_valid = !fifo_empty;
  assign periph_id    = head.id;
  assign periph_data  = head.data;

  // Sticky overflow: a dropped push sets it, a status write with the clear bit clears it.
  always_comb begin
    overflow_d = overflow_q;
    if (io_strb && is_status && out_port[CTRL_CLR_OVF]) overflow_d = 1'b0;
    if (push && fifo_full && !pop)                     overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end

  always_comb begin
    in_port = periph_rd_data;
    if (is_status) begin
      in_port                = 8'h00;
      in_port[STAT_FULL]     = fifo_full;
      in_port[STAT_VALID]    = periph_valid;
      in_port[STAT_OVF]      = overflow_q;
    end
  end

`ifdef IO_BRIDGE_IRQ_EN
  logic irq_q, irq_d;

  // Pulse the cycle after the last queued entry drains with nothing arriving.
  assign irq_d = (fifo_count == CW'(1)) && pop && !push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  end

  assign irq = irq_q;
`else
  logic unused_count;
  assign unused_count = ^fifo_count;
  assign irq          = 1'b0;
`endif

endmodule

// File: tb/tb_io_port_bridge.sv
// Directed table-driven bench for io_port_bridge plus a mid-drain reset sequence.
module tb_io_port_bridge;

`ifdef IO_BRIDGE_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       io_strb;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic [7:0] in_port;
  logic [7:0] periph_rd_data;
  logic       periph_valid;
  logic [7:0] periph_id;
  logic [7:0] periph_data;
  logic       periph_ready;
  logic       fifo_full;
  logic       irq;

  int checks   = 0;
  int failures = 0;

  io_port_bridge dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .io_strb        (io_strb),
    .port_id        (port_id),
    .out_port       (out_port),
    .in_port        (in_port),
    .periph_rd_data (periph_rd_data),
    .periph_valid   (periph_valid),
    .periph_id      (periph_id),
    .periph_data    (periph_data),
    .periph_ready   (periph_ready),
    .fifo_full      (fifo_full),
    .irq            (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       strb;
    logic [7:0] id;
    logic [7:0] data;
    logic       rdy;
    logic [7:0] rd;
    logic       e_valid;
    logic [7:0] e_id;
    logic [7:0] e_data;
    logic       e_full;
    logic [7:0] e_in;
    logic       e_irq;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Expected outputs describe the state seen before each vector's clock edge.
    //           strb  id     data   rdy   rd     valid  id     data   full  in     irq
    vecs[0]  = '{1'b1, 8'h10, 8'hA5, 1'b1, 8'h3C, 1'b0, 8'h00, 8'h00, 1'b0, 8'h3C, 1'b0};
    vecs[1]  = '{1'b0, 8'h10, 8'h00, 1'b1, 8'h5A, 1'b1, 8'h10, 8'hA5, 1'b0, 8'h5A, 1'b0};
    vecs[2]  = '{1'b0, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, IRQ_ON};
    vecs[3]  = '{1'b1, 8'h01, 8'h11, 1'b0, 8'h77, 1'b0, 8'h00, 8'h00, 1'b0, 8'h77, 1'b0};
    vecs[4]  = '{1'b1, 8'h02, 8'h22, 1'b0, 8'h77, 1'b1, 8'h01, 8'h11, 1'b0, 8'h77, 1'b0};
    vecs[5]  = '{1'b1, 8'h03, 8'h33, 1'b0, 8'h77, 1'b1, 8'h01, 8'h11, 1'b0, 8'h77, 1'b0};
    vecs[6]  = '{1'b1, 8'h04, 8'h44, 1'b0, 8'h77, 1'b1, 8'h01, 8'h11, 1'b0, 8'h77, 1'b0};
    vecs[7]  = '{1'b0, 8'hFF, 8'h00, 1'b0, 8'h77, 1'b1, 8'h01, 8'h11, 1'b1, 8'h03, 1'b0};
    vecs[8]  = '{1'b1, 8'h05, 8'h55, 1'b0, 8'h99, 1'b1, 8'h01, 8'h11, 1'b1, 8'h99, 1'b0};
    vecs[9]  = '{1'b0, 8'hFF, 8'h00, 1'b0, 8'h99, 1'b1, 8'h01, 8'h11, 1'b1, 8'h07, 1'b0};
    vecs[10] = '{1'b1, 8'hFF, 8'h01, 1'b0, 8'h99, 1'b1, 8'h01, 8'h11, 1'b1, 8'h07, 1'b0};
    vecs[11] = '{1'b0, 8'hFF, 8'h00, 1'b0, 8'h99, 1'b1, 8'h01, 8'h11, 1'b1, 8'h03, 1'b0};
    vecs[12] = '{1'b1, 8'h06, 8'h66, 1'b1, 8'hAB, 1'b1, 8'h01, 8'h11, 1'b1, 8'hAB, 1'b0};
    vecs[13] = '{1'b0, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 8'h02, 8'h22, 1'b1, 8'h03, 1'b0};
    vecs[14] = '{1'b0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 8'h02, 8'h22, 1'b1, 8'h03, 1'b0};
    vecs[15] = '{1'b0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 8'h03, 8'h33, 1'b0, 8'h02, 1'b0};
    vecs[16] = '{1'b0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 8'h04, 8'h44, 1'b0, 8'h02, 1'b0};
    vecs[17] = '{1'b0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 8'h06, 8'h66, 1'b0, 8'h02, 1'b0};
    vecs[18] = '{1'b0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, IRQ_ON};
    vecs[19] = '{1'b0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};

    rst_n          = 1'b0;
    io_strb        = 1'b0;
    port_id        = 8'h00;
    out_port       = 8'h00;
    periph_rd_data = 8'h00;
    periph_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    port_id = 8'hFF;
    #1;
    check("reset_valid", 0, 8'(periph_valid), 8'h00);
    check("reset_full",  0, 8'(fifo_full),    8'h00);
    check("reset_irq",   0, 8'(irq),          8'h00);
    check("reset_id",    0, periph_id,        8'h00);
    check("reset_data",  0, periph_data,      8'h00);
    check("reset_stat",  0, in_port,          8'h00);
    step();

    for (int i = 0; i < 20; i++) begin
      io_strb        = vecs[i].strb;
      port_id        = vecs[i].id;
      out_port       = vecs[i].data;
      periph_ready   = vecs[i].rdy;
      periph_rd_data = vecs[i].rd;
      #2;
      check("valid",   i, 8'(periph_valid), 8'(vecs[i].e_valid));
      check("full",    i, 8'(fifo_full),    8'(vecs[i].e_full));
      check("in_port", i, in_port,          vecs[i].e_in);
      check("irq",     i, 8'(irq),          8'(vecs[i].e_irq));
      if (vecs[i].e_valid) begin
        check("head_id",   i, periph_id,   vecs[i].e_id);
        check("head_data", i, periph_data, vecs[i].e_data);
      end
      step();
    end

    // Queue three entries, then assert reset between clock edges.
    periph_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      io_strb  = 1'b1;
      port_id  = 8'(8'h07 + k);
      out_port = 8'(8'h70 + k);
      step();
    end
    io_strb = 1'b0;
    port_id = 8'hFF;
    #1;
    check("pre_rst_stat", 0, in_port,   8'h02);
    check("pre_rst_id",   0, periph_id, 8'h07);
    #1 rst_n = 1'b0;
    #1;
    check("async_valid", 0, 8'(periph_valid), 8'h00);
    check("async_full",  0, 8'(fifo_full),    8'h00);
    check("async_stat",  0, in_port,          8'h00);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_valid", 0, 8'(periph_valid), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
